turn_controller: RTL and testbench
==================================

// Module: turn_controller
// PURPOSE
// - Sequences one Connect-4 move: accepts the current player's column request and validates it.
// - Drives one board-RAM write, starts the win checker, then advances the turn.
// - Holds turn state (replaces the standalone turn toggle) and per-column fill heights.
// - Sits between the player input decoder, board memory and win-check datapath.
// PARAMETERS
// - COLS            7           number of board columns (col index 0..COLS-1)
// - ROWS            6           number of board rows; height counter saturates at ROWS
// - TIMEOUT_CYCLES  50_000_000  idle cycles before a forfeited turn (TURN_TIMEOUT_EN only)
// PORTS
// - clk       in   1  system clock, all state on posedge
// - reset     in   1  asynchronous, active-low reset
// - new_game  in   1  sync restart, priority over everything except reset
// - drop_req  in   1  move request, level; accepted on rising edge only
// - drop_col  in   3  requested column, sampled with the accepted edge
// - drop_ack  out  1  1-cycle pulse: move accepted (coincides with wr_en)
// - drop_rej  out  1  1-cycle pulse: column >= COLS or column full
// - wr_en     out  1  1-cycle board write strobe
// - wr_row    out  3  row written (0 = bottom)
// - wr_col    out  3  column written
// - wr_color  out  2  01 = player 1, 10 = player 2
// - chk_start out  1  1-cycle pulse to win checker, cycle after wr_en
// - chk_done  in   1  win checker finished (any latency >= 1 cycle)
// - chk_win   in   1  valid with chk_done: last move wins
// - turn      out  1  0 = player 1, 1 = player 2
// - game_over out  1  level, set in OVER
// - winner    out  2  00 none/draw, 01 P1, 10 P2; valid when game_over
// - timeout   out  1  1-cycle pulse: turn forfeited
// BEHAVIOUR
// - Reset (async, reset=0): state=IDLE; turn=0; heights=0; move count=0; all outputs 0.
// - new_game=1: same clear, synchronously, next cycle in IDLE; pending chk_done dropped.
// - Rising edge: drop_req=1 and registered previous drop_req=0.
// - FSM IDLE: on rising edge, latch drop_col -> VALIDATE.
// - FSM VALIDATE: col>=COLS or height[col]==ROWS -> pulse drop_rej, -> IDLE; else -> WRITE.
// - FSM WRITE: wr_en=drop_ack=1; wr_row=height[col]; wr_color={turn,~turn}.
//   Increments height[col] and move count; -> CHECK.
// - FSM CHECK: chk_start=1 on the entry cycle only; wait for chk_done.
//   chk_win=1 -> OVER, winner=wr_color.
//   Else move count==COLS*ROWS -> OVER, winner=00.
//   Else -> NEXT.
// - FSM NEXT: turn<=~turn; -> IDLE.
// - FSM OVER: game_over=1; all drop_req ignored until new_game.
// - Latency: accepted edge to wr_en = 2 cycles; chk_done to turn change = 2 cycles.
// - Edges in VALIDATE/WRITE/CHECK/NEXT are ignored, not queued.
// - drop_req held high never re-triggers.
// - chk_done outside CHECK is ignored.
// - wr_row/wr_col/wr_color hold their last value between writes.
// CONFIGURATION
// - TURN_TIMEOUT_EN defined:
//   - A counter runs in IDLE; it clears on any state exit and on new_game.
//   - When it reaches TIMEOUT_CYCLES-1 with no edge: timeout pulses for 1 cycle.
//     turn toggles in that same cycle; the counter clears.
//   - An edge in that same cycle wins: no timeout is raised.
// - TURN_TIMEOUT_EN undefined: no counter logic; timeout tied 0; port list unchanged.
// TESTING
// - reset=0 mid-CHECK -> next cycle: state IDLE, turn=0, all heights 0, wr_en=0, game_over=0.
// - P1 edge col=3 -> cycle+2: wr_en=1, wr_row=0, wr_col=3, wr_color=01; chk_done=1, chk_win=0 -> turn=1.
// - 6 accepted drops in col 0, then a 7th -> drop_rej pulse, no wr_en, turn unchanged.
// - drop_col=7 -> drop_rej.
// - P2 move, chk_done=1 with chk_win=1 -> game_over=1, winner=10.
//   Further drop_req edges give no wr_en until new_game, then turn=0, winner=00.
// - Fill 42 cells with chk_win=0 -> game_over=1, winner=00 after the 42nd chk_done.
// - TURN_TIMEOUT_EN, TIMEOUT_CYCLES=16: idle 16 cycles -> timeout pulse, turn 0->1, no wr_en.
//   Edge on cycle 16 -> move accepted, no timeout.

Source files
------------

// File: rtl/turn_controller_if.sv
// Connect-4 move sequencer bus: player request, board-RAM write, win-checker handshake and game status.
// The slave modport is the turn_controller side; the master modport is the surrounding system.
interface turn_controller_if;
    logic       new_game;
    logic       drop_req;
    logic [2:0] drop_col;
    logic       drop_ack;
    logic       drop_rej;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [1:0] wr_color;
    logic       chk_start;
    logic       chk_done;
    logic       chk_win;
    logic       turn;
    logic       game_over;
    logic [1:0] winner;
    logic       timeout;

    modport slave (
        input  new_game, drop_req, drop_col, chk_done, chk_win,
        output drop_ack, drop_rej, wr_en, wr_row, wr_col, wr_color,
        output chk_start, turn, game_over, winner, timeout
    );

    modport master (
        output new_game, drop_req, drop_col, chk_done, chk_win,
        input  drop_ack, drop_rej, wr_en, wr_row, wr_col, wr_color,
        input  chk_start, turn, game_over, winner, timeout
    );
endinterface

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: validates a column request, writes the board, runs the win check, advances the turn.
// Optional idle-turn forfeit counter is enabled by defining TURN_TIMEOUT_EN.
module turn_controller #(
    parameter int COLS           = 7,
    parameter int ROWS           = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic               clk,
    input logic               reset,
    turn_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_VALIDATE, S_WRITE, S_CHECK, S_NEXT, S_OVER
    } state_t;

    localparam int              MW        = $clog2(COLS * ROWS + 1);
    localparam logic [MW-1:0]   MOVES_MAX = MW'(COLS * ROWS);
    localparam logic [2:0]      ROWS_H    = 3'(ROWS);
    localparam logic [3:0]      COLS_C    = 4'(COLS);

    state_t          r_state, w_next;
    logic            r_drop_prev;
    logic [2:0]      r_col;
    logic [2:0]      r_height [COLS];
    logic [MW-1:0]   r_moves;
    logic            r_turn;
    logic            r_chk_entry;
    logic [2:0]      r_wr_row, r_wr_col;
    logic [1:0]      r_wr_color, r_winner;
    logic            w_rise, w_col_ok, w_col_full, w_over;
    logic            w_wr, w_rej, w_chk_start, w_timeout;

    assign w_rise     = bus.drop_req & ~r_drop_prev;
    assign w_col_ok   = ({1'b0, r_col} < COLS_C);
    assign w_col_full = w_col_ok && (r_height[r_col] == ROWS_H);
    assign w_over     = bus.chk_win || (r_moves == MOVES_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_wr        = 1'b0;
        w_rej       = 1'b0;
        w_chk_start = 1'b0;
        if (bus.new_game) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_rise) w_next = S_VALIDATE;
                S_VALIDATE: begin
                    if (!w_col_ok || w_col_full) begin
                        w_rej  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_WRITE;
                    end
                end
                S_WRITE: begin
                    w_wr   = 1'b1;
                    w_next = S_CHECK;
                end
                S_CHECK: begin
                    w_chk_start = r_chk_entry;
                    if (bus.chk_done) w_next = w_over ? S_OVER : S_NEXT;
                end
                S_NEXT:     w_next = S_IDLE;
                S_OVER:     w_next = S_OVER;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // NOTE: the height table is a handful of flops, not RAM, so it is cleared by reset like any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_prev <= 1'b0;
            r_col       <= '0;
            r_moves     <= '0;
            r_turn      <= 1'b0;
            r_chk_entry <= 1'b0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_wr_color  <= '0;
            r_winner    <= '0;
            for (int i = 0; i < COLS; i++) r_height[i] <= '0;
        end else begin
            r_drop_prev <= bus.drop_req;
            r_chk_entry <= (r_state == S_WRITE) && !bus.new_game;
            if (bus.new_game) begin
                r_moves    <= '0;
                r_turn     <= 1'b0;
                r_wr_row   <= '0;
                r_wr_col   <= '0;
                r_wr_color <= '0;
                r_winner   <= '0;
                for (int i = 0; i < COLS; i++) r_height[i] <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise)    r_col  <= bus.drop_col;
                        if (w_timeout) r_turn <= ~r_turn;
                    end
                    S_VALIDATE: if (w_next == S_WRITE) begin
                        r_wr_row   <= r_height[r_col];
                        r_wr_col   <= r_col;
                        r_wr_color <= {r_turn, ~r_turn};
                    end
                    S_WRITE: begin
                        r_height[r_col] <= r_height[r_col] + 3'd1;
                        r_moves         <= r_moves + 1'b1;
                    end
                    S_CHECK: if (bus.chk_done && w_over)
                        r_winner <= bus.chk_win ? r_wr_color : 2'b00;
                    S_NEXT:  r_turn <= ~r_turn;
                    default: ;
                endcase
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int            TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_idle_cnt;

    // A request arriving on the terminal count takes precedence over the forfeit.
    assign w_timeout = (r_state == S_IDLE) && !w_rise && !bus.new_game && (r_idle_cnt == T_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_idle_cnt <= '0;
        else if (bus.new_game || r_state != S_IDLE || w_rise || w_timeout)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + 1'b1;
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    assign bus.drop_ack  = w_wr;
    assign bus.wr_en     = w_wr;
    assign bus.drop_rej  = w_rej;
    assign bus.chk_start = w_chk_start;
    assign bus.wr_row    = r_wr_row;
    assign bus.wr_col    = r_wr_col;
    assign bus.wr_color  = r_wr_color;
    assign bus.turn      = r_turn;
    assign bus.game_over = (r_state == S_OVER);
    assign bus.winner    = r_winner;
    assign bus.timeout   = w_timeout;
endmodule

// File: tb/tb_turn_controller.sv
// Directed self-checking bench for turn_controller: moves, rejects, reset, win, draw and (optionally) turn timeout.
`timescale 1ns/1ps
module tb_turn_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the board occupancy and turn
    int   m_height [7];
    int   m_moves;
    logic m_turn;

    turn_controller_if bus_if ();

    turn_controller #(.COLS(7), .ROWS(6), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 7; i++) m_height[i] = 0;
        m_moves = 0;
        m_turn  = 1'b0;
    endtask

    task automatic play_move(input logic [2:0] col, input logic win, input logic hold);
        logic [1:0] color;
        logic       over;
        color = {m_turn, ~m_turn};
        bus_if.drop_col = col;
        bus_if.drop_req = 1'b1;
        tick();
        if (!hold) bus_if.drop_req = 1'b0;
        check("no_rej", bus_if.drop_rej, 1'b0);
        check("wr_not_early", bus_if.wr_en, 1'b0);
        tick();
        check("wr_en", bus_if.wr_en, 1'b1);
        check("drop_ack", bus_if.drop_ack, 1'b1);
        check("wr_row", bus_if.wr_row, 32'(m_height[col]));
        check("wr_col", bus_if.wr_col, col);
        check("wr_color", bus_if.wr_color, color);
        m_height[col]++;
        m_moves++;
        tick();
        check("chk_start", bus_if.chk_start, 1'b1);
        check("wr_en_1cyc", bus_if.wr_en, 1'b0);
        tick();
        check("chk_start_1cyc", bus_if.chk_start, 1'b0);
        check("turn_hold", bus_if.turn, m_turn);
        bus_if.chk_done = 1'b1;
        bus_if.chk_win  = win;
        tick();
        bus_if.chk_done = 1'b0;
        bus_if.chk_win  = 1'b0;
        over = win || (m_moves == 42);
        tick();
        check("game_over", bus_if.game_over, over);
        if (over) begin
            check("winner", bus_if.winner, win ? color : 2'b00);
        end else begin
            m_turn = ~m_turn;
            check("turn_adv", bus_if.turn, m_turn);
        end
    endtask

    task automatic expect_reject(input logic [2:0] col);
        bus_if.drop_col = col;
        bus_if.drop_req = 1'b1;
        tick();
        bus_if.drop_req = 1'b0;
        check("drop_rej", bus_if.drop_rej, 1'b1);
        check("rej_no_ack", bus_if.drop_ack, 1'b0);
        tick();
        check("rej_no_wr", bus_if.wr_en, 1'b0);
        check("rej_1cyc", bus_if.drop_rej, 1'b0);
        check("rej_turn", bus_if.turn, m_turn);
    endtask

    task automatic pulse_new_game();
        bus_if.new_game = 1'b1;
        tick();
        bus_if.new_game = 1'b0;
        model_clear();
    endtask

    initial begin
        logic seen;
        reset            = 1'b0;
        bus_if.new_game  = 1'b0;
        bus_if.drop_req  = 1'b0;
        bus_if.drop_col  = '0;
        bus_if.chk_done  = 1'b0;
        bus_if.chk_win   = 1'b0;
        model_clear();
        tick(); tick();
        check("rst_wr_en", bus_if.wr_en, 1'b0);
        check("rst_turn", bus_if.turn, 1'b0);
        check("rst_game_over", bus_if.game_over, 1'b0);
        check("rst_winner", bus_if.winner, 2'b00);
        check("rst_timeout", bus_if.timeout, 1'b0);
        check("rst_wr_row", bus_if.wr_row, 3'd0);
        reset = 1'b1;
        tick();

        // P1 drops in column 3; no win
        play_move(3'd3, 1'b0, 1'b0);
        check("wr_row_held", bus_if.wr_row, 3'd0);
        check("wr_col_held", bus_if.wr_col, 3'd3);

        // Stray checker completion in IDLE must not end the game
        bus_if.chk_done = 1'b1;
        bus_if.chk_win  = 1'b1;
        tick(); tick();
        bus_if.chk_done = 1'b0;
        bus_if.chk_win  = 1'b0;
        tick();
        check("stray_done_over", bus_if.game_over, 1'b0);
        check("stray_done_turn", bus_if.turn, m_turn);

        // drop_req held high after a move never re-triggers
        play_move(3'd2, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= bus_if.wr_en;
        end
        check("held_no_retrigger", seen, 1'b0);
        bus_if.drop_req = 1'b0;
        tick();

        // Fill column 0, then a 7th drop is rejected
        for (int i = 0; i < 6; i++) play_move(3'd0, 1'b0, 1'b0);
        expect_reject(3'd0);
        expect_reject(3'd7);

        // Reset in the middle of CHECK
        play_move(3'd6, 1'b0, 1'b0);
        check("pre_reset_turn", bus_if.turn, 1'b1);
        bus_if.drop_col = 3'd5;
        bus_if.drop_req = 1'b1;
        tick();
        bus_if.drop_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("midrst_turn", bus_if.turn, 1'b0);
        check("midrst_wr_en", bus_if.wr_en, 1'b0);
        check("midrst_chk_start", bus_if.chk_start, 1'b0);
        check("midrst_game_over", bus_if.game_over, 1'b0);
        reset = 1'b1;
        model_clear();
        tick();

        // Column 0 lands at row 0 again; P2 then wins
        play_move(3'd0, 1'b0, 1'b0);
        play_move(3'd2, 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus_if.drop_col = 3'd4;
            bus_if.drop_req = 1'b1;
            tick(); tick();
            seen |= bus_if.wr_en;
            bus_if.drop_req = 1'b0;
            tick();
            seen |= bus_if.wr_en;
        end
        check("over_ignores_drop", seen, 1'b0);
        check("over_holds", bus_if.game_over, 1'b1);
        check("over_winner_p2", bus_if.winner, 2'b10);
        pulse_new_game();
        check("ng_turn", bus_if.turn, 1'b0);
        check("ng_winner", bus_if.winner, 2'b00);
        check("ng_game_over", bus_if.game_over, 1'b0);

        // Fill the whole board without a win: draw on the 42nd move
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                play_move(3'(c), 1'b0, 1'b0);
        check("draw_over", bus_if.game_over, 1'b1);
        check("draw_winner", bus_if.winner, 2'b00);
        pulse_new_game();

`ifdef TURN_TIMEOUT_EN
        // 16 idle cycles forfeit the turn
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen |= bus_if.timeout;
            tick();
        end
        check("to_not_early", seen, 1'b0);
        check("to_pulse", bus_if.timeout, 1'b1);
        tick();
        check("to_1cyc", bus_if.timeout, 1'b0);
        check("to_turn", bus_if.turn, 1'b1);
        check("to_no_wr", bus_if.wr_en, 1'b0);
        m_turn = 1'b1;
        pulse_new_game();
        // An edge on the 16th idle cycle beats the forfeit
        for (int i = 0; i < 15; i++) tick();
        bus_if.drop_col = 3'd4;
        bus_if.drop_req = 1'b1;
        #1;
        check("to_edge_wins", bus_if.timeout, 1'b0);
        play_move(3'd4, 1'b0, 1'b0);
`else
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= bus_if.timeout;
        end
        check("timeout_tied_low", seen, 1'b0);
        check("idle_turn_kept", bus_if.turn, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
